round_judge: RTL and testbench
==============================

# round_judge

Parametrised round-judging and scoring engine for the cat/dog/chicken game, generalised to any odd number of choices. It sits between the switch inputs and the screen controller. On a user commit it captures both players' one-hot choices and decodes a one-hot scenario vector of N×N bits. It then resolves winner or draw, updates saturating per-player scores, and holds the result until the controller acknowledges that the screen draw is finished.

## Interface
- NUM_CHOICES, 3, number of choices; must be odd and ≥3.
- SCORE_W, 4, width of each score counter.
- WIN_TARGET, 9, score that ends the game; must satisfy 1 ≤ WIN_TARGET ≤ 2^SCORE_W−1.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- stateReset  in  1  synchronous, active-high reset.
- userChoose  in  1  commit-round request; level, sampled only in IDLE.
- userResetGame  in  1  clears scores and returns to IDLE.
- player1Choice  in  NUM_CHOICES  one-hot choice for player 1.
- player2Choice  in  NUM_CHOICES  one-hot choice for player 2.
- resultAck  in  1  screen done; releases the held result.
- scenario  out  NUM_CHOICES*NUM_CHOICES  one-hot scenario. Bit (i*NUM_CHOICES + j) means p1 chose i and p2 chose j.
- resultValid  out  1  scenario and winner flags are valid.
- winner1, winner2, draw  out  1 each  round outcome; exactly one is high while resultValid=1.
- player1, player2  out  SCORE_W each  scores.
- gameOver  out  1  a score has reached WIN_TARGET.
- busy  out  1  high in every state other than IDLE.

## Operation
- FSM states: IDLE, JUDGE, SHOW, OVER.
- IDLE + userChoose=1: both choices are registered and the FSM goes to JUDGE.
- JUDGE (one cycle):
  - Decode each registered choice to an index.
  - Set scenario.
  - Resolve the outcome:
    - index i beats index j iff (j − i) mod N ∈ [1, (N−1)/2];
    - i = j is a draw.
  - Increment the winner's score, saturating at WIN_TARGET.
  - Go to SHOW.
- SHOW: hold all outputs.
  - resultAck=1 → OVER if either score equals WIN_TARGET, else IDLE.
  - On the exit to IDLE, resultValid, winner1, winner2 and draw clear. scenario holds its last value.
- OVER: gameOver=1. userChoose is ignored. Only userResetGame or stateReset leave this state.
- userResetGame in any state:
  - scores = 0;
  - all flags = 0;
  - scenario = 0;
  - next state IDLE.
  - It has priority over userChoose and resultAck in the same cycle.
- stateReset: same effect as userResetGame, with highest priority.
- Reset values of all outputs are 0, except busy=0 (IDLE).
- userChoose held high across several cycles: it is re-sampled only on return to IDLE, so a held key starts a new round immediately after the ack. The controller is responsible for edge-qualifying the key.
- resultAck outside SHOW: ignored.
- Invalid choice (not exactly one bit set): handled per Configuration.

## Timing
- Cycle 0: userChoose=1 in IDLE → choices captured.
- Cycle 1: JUDGE.
- Cycle 2: resultValid=1; scores already updated and visible; busy=1 since cycle 1.
- Minimum round length is 3 cycles from commit to IDLE, with resultAck asserted in cycle 2.
- gameOver rises the cycle after the acknowledging resultAck.
- Score saturation: a win at WIN_TARGET leaves the score unchanged. This is unreachable under normal flow because OVER blocks further rounds.

## Configuration
- ROUND_JUDGE_INVALID_FORFEIT_EN defined:
  - A player with an invalid choice loses the round; both invalid is a draw.
  - The scenario bit uses index 0 for the invalid player.
- Not defined: an invalid choice is treated as index 0 (cat), matching the legacy default.

## Structure
- Package round_judge_pkg holds:
  - the state enum (IDLE, JUDGE, SHOW, OVER);
  - constant-function beats(i, j, n);
  - named indices CAT=0, DOG=1, CHICKEN=2.
- Sub-module onehot_encode, parametrised by width, with outputs index [$clog2(W)-1:0] and valid (exactly one bit set). It is instantiated twice.

## Test plan
- Reset then p1=001 (cat), p2=010 (dog), userChoose pulse → cycle 2: resultValid=1, scenario bit 1 set, winner1=1, player1=1, player2=0.
- p1=p2=100 (chicken) → draw=1, scenario bit 8 set, scores unchanged; resultAck → IDLE, busy=0 next cycle.
- WIN_TARGET=2, p1 wins twice with acks → after the second ack gameOver=1; a further userChoose is ignored; userResetGame → scores 0, IDLE.
- p1=011, p2=010:
  - with ROUND_JUDGE_INVALID_FORFEIT_EN → winner2=1;
  - without → p1 is treated as cat, winner1=1.
- NUM_CHOICES=5 sweep of all 25 pairs → each non-diagonal pair gives exactly one winner per beats(); each scenario is one-hot at bit i*5+j.
- userResetGame and resultAck asserted together in SHOW → IDLE, scores 0, gameOver stays 0.

Source files
------------

// File: rtl/round_judge_pkg.sv
// -----------------------------------------------------------------------------
// round_judge_pkg
// Shared definitions for the round judging engine: FSM state encoding, named
// choice indices for the classic three-choice game, and the cyclic "beats"
// rule used to resolve a round for any odd number of choices.
// Optional feature macro used by the engine: ROUND_JUDGE_INVALID_FORFEIT_EN.
// -----------------------------------------------------------------------------
package round_judge_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      JUDGE = 2'd1,
      SHOW  = 2'd2,
      OVER  = 2'd3
   } state_t;

   localparam int CAT     = 0;
   localparam int DOG     = 1;
   localparam int CHICKEN = 2;

   // i beats j when j lies 1..(n-1)/2 steps after i around the circle.
   // Indices are always below n, so one conditional subtraction replaces mod.
   function automatic logic beats(input int unsigned i, input int unsigned j,
                                  input int unsigned n);
      int unsigned d;
      d = j + n - i;
      if (d >= n) begin
         d = d - n;
      end else begin
         d = d;
      end
      return (d >= 32'd1) && (d <= ((n - 32'd1) / 32'd2));
   endfunction

endpackage

// File: rtl/round_judge_if.sv
// -----------------------------------------------------------------------------
// round_judge_if
// Bundles the controller-facing signals of the round judge.
//   master : screen/switch controller (drives commit, choices, ack, game reset)
//   slave  : round_judge (drives scenario, outcome flags, scores, status)
// -----------------------------------------------------------------------------
interface round_judge_if #(
   parameter int NUM_CHOICES = 3,
   parameter int SCORE_W     = 4
);
   logic                               userChoose;
   logic                               userResetGame;
   logic [NUM_CHOICES-1:0]             player1Choice;
   logic [NUM_CHOICES-1:0]             player2Choice;
   logic                               resultAck;
   logic [NUM_CHOICES*NUM_CHOICES-1:0] scenario;
   logic                               resultValid;
   logic                               winner1;
   logic                               winner2;
   logic                               draw;
   logic [SCORE_W-1:0]                 player1;
   logic [SCORE_W-1:0]                 player2;
   logic                               gameOver;
   logic                               busy;

   modport master (
      output userChoose, userResetGame, player1Choice, player2Choice, resultAck,
      input  scenario, resultValid, winner1, winner2, draw,
             player1, player2, gameOver, busy
   );

   modport slave (
      input  userChoose, userResetGame, player1Choice, player2Choice, resultAck,
      output scenario, resultValid, winner1, winner2, draw,
             player1, player2, gameOver, busy
   );
endinterface

// File: rtl/round_judge_onehot_encode.sv
// -----------------------------------------------------------------------------
// onehot_encode
// Converts a one-hot vector into its bit index.
//   vec   in  W           candidate one-hot vector
//   index out $clog2(W)   position of the set bit (0 when not valid)
//   valid out 1           exactly one bit of vec is set
// -----------------------------------------------------------------------------
module onehot_encode #(
   parameter int W = 3
) (
   input  logic [W-1:0]         vec,
   output logic [$clog2(W)-1:0] index,
   output logic                 valid
);
   localparam int IW = $clog2(W);

   logic [IW-1:0] acc_s;

   // Exactly-one test: non-zero and clearing the lowest set bit leaves zero.
   assign valid = (vec != '0) && ((vec & (vec - W'(1))) == '0);

   // OR together the positions of set bits; only meaningful when valid.
   always_comb begin
      acc_s = '0;
      for (int i = 0; i < W; i++) begin
         acc_s = acc_s | (vec[i] ? IW'(i) : '0);
      end
      index = valid ? acc_s : '0;
   end
endmodule

// File: rtl/round_judge.sv
// -----------------------------------------------------------------------------
// round_judge
// Round judging and scoring engine for the cat/dog/chicken game generalised to
// any odd NUM_CHOICES. Captures both choices on commit, judges one cycle later,
// holds the result until the screen acknowledges it, and keeps saturating
// per-player scores. Enters OVER once a score hits WIN_TARGET.
//   clk        in  system clock
//   stateReset in  synchronous active-high reset (highest priority)
//   bus        slave side of round_judge_if (commit/ack/choices in,
//              scenario/outcome/scores/status out, all registered)
// Optional feature: ROUND_JUDGE_INVALID_FORFEIT_EN -- a player whose choice is
// not one-hot forfeits the round (both invalid is a draw). Without it an
// invalid choice is judged as index 0 (cat).
// -----------------------------------------------------------------------------
module round_judge
   import round_judge_pkg::*;
#(
   parameter int NUM_CHOICES = 3,
   parameter int SCORE_W     = 4,
   parameter int WIN_TARGET  = 9
) (
   input logic         clk,
   input logic         stateReset,
   round_judge_if.slave bus
);
   localparam int IW = $clog2(NUM_CHOICES);
   localparam int SW = NUM_CHOICES * NUM_CHOICES;
   localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);

   state_t                 state_r;
   logic [NUM_CHOICES-1:0] p1_r, p2_r;
   logic [SW-1:0]          scenario_r;
   logic                   valid_r, win1_r, win2_r, draw_r, over_r, busy_r;
   logic [SCORE_W-1:0]     score1_r, score2_r;

   logic [IW-1:0]          idx1_s, idx2_s, eff1_s, eff2_s;
   logic                   ok1_s, ok2_s;
   logic                   win1_s, win2_s, draw_s;
   logic [31:0]            sel_s;
   logic [SW-1:0]          scen_s;

   onehot_encode #(.W(NUM_CHOICES)) u_enc1 (.vec(p1_r), .index(idx1_s), .valid(ok1_s));
   onehot_encode #(.W(NUM_CHOICES)) u_enc2 (.vec(p2_r), .index(idx2_s), .valid(ok2_s));

   // Invalid choices map to index 0 for both scenario and default judging.
   assign eff1_s = ok1_s ? idx1_s : '0;
   assign eff2_s = ok2_s ? idx2_s : '0;

   // Decode scenario bit and resolve the round from the captured choices.
   always_comb begin
      win1_s = 1'b0;
      win2_s = 1'b0;
      draw_s = 1'b0;
      sel_s  = 32'(eff1_s) * 32'(NUM_CHOICES) + 32'(eff2_s);
      scen_s = SW'(1) << sel_s;
`ifdef ROUND_JUDGE_INVALID_FORFEIT_EN
      if (!ok1_s && !ok2_s) begin
         draw_s = 1'b1;
      end else if (!ok1_s) begin
         win2_s = 1'b1;
      end else if (!ok2_s) begin
         win1_s = 1'b1;
      end else if (eff1_s == eff2_s) begin
         draw_s = 1'b1;
      end else if (beats(32'(eff1_s), 32'(eff2_s), NUM_CHOICES)) begin
         win1_s = 1'b1;
      end else begin
         win2_s = 1'b1;
      end
`else
      if (eff1_s == eff2_s) begin
         draw_s = 1'b1;
      end else if (beats(32'(eff1_s), 32'(eff2_s), NUM_CHOICES)) begin
         win1_s = 1'b1;
      end else begin
         win2_s = 1'b1;
      end
`endif
   end

   // Round FSM with registered outputs; game reset outranks commit and ack.
   always_ff @(posedge clk) begin
      if (stateReset || bus.userResetGame) begin
         state_r    <= IDLE;
         p1_r       <= '0;
         p2_r       <= '0;
         scenario_r <= '0;
         valid_r    <= 1'b0;
         win1_r     <= 1'b0;
         win2_r     <= 1'b0;
         draw_r     <= 1'b0;
         over_r     <= 1'b0;
         busy_r     <= 1'b0;
         score1_r   <= '0;
         score2_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.userChoose) begin
                  p1_r    <= bus.player1Choice;
                  p2_r    <= bus.player2Choice;
                  busy_r  <= 1'b1;
                  state_r <= JUDGE;
               end
            end
            JUDGE: begin
               scenario_r <= scen_s;
               valid_r    <= 1'b1;
               win1_r     <= win1_s;
               win2_r     <= win2_s;
               draw_r     <= draw_s;
               if (win1_s && (score1_r < TARGET)) begin
                  score1_r <= score1_r + SCORE_W'(1);
               end
               if (win2_s && (score2_r < TARGET)) begin
                  score2_r <= score2_r + SCORE_W'(1);
               end
               state_r <= SHOW;
            end
            SHOW: begin
               if (bus.resultAck) begin
                  valid_r <= 1'b0;
                  win1_r  <= 1'b0;
                  win2_r  <= 1'b0;
                  draw_r  <= 1'b0;
                  if ((score1_r == TARGET) || (score2_r == TARGET)) begin
                     over_r  <= 1'b1;
                     state_r <= OVER;
                  end else begin
                     busy_r  <= 1'b0;
                     state_r <= IDLE;
                  end
               end
            end
            OVER: begin
               state_r <= OVER;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.scenario    = scenario_r;
   assign bus.resultValid = valid_r;
   assign bus.winner1     = win1_r;
   assign bus.winner2     = win2_r;
   assign bus.draw        = draw_r;
   assign bus.player1     = score1_r;
   assign bus.player2     = score2_r;
   assign bus.gameOver    = over_r;
   assign bus.busy        = busy_r;
endmodule

// File: tb/tb_round_judge.sv
// -----------------------------------------------------------------------------
// tb_round_judge
// Self-checking bench for round_judge. Three instances: the default 3-choice
// game (target 9), a 3-choice game with target 2, and a 5-choice game.
// Expected outcomes come from a reference model built directly on the game
// rules: count set bits to find a choice, then compare positions around the
// circle with modular arithmetic.
// -----------------------------------------------------------------------------
module tb_round_judge;
   logic clk;
   logic rst;
   int   tests;
   int   fails;
   int   sa1, sa2;   // model scores for instance a
   int   sc1, sc2;   // model scores for instance c

   round_judge_if #(.NUM_CHOICES(3), .SCORE_W(4)) a_if ();
   round_judge_if #(.NUM_CHOICES(3), .SCORE_W(4)) b_if ();
   round_judge_if #(.NUM_CHOICES(5), .SCORE_W(4)) c_if ();

   round_judge #(.NUM_CHOICES(3), .SCORE_W(4), .WIN_TARGET(9))  dut_a (.clk(clk), .stateReset(rst), .bus(a_if));
   round_judge #(.NUM_CHOICES(3), .SCORE_W(4), .WIN_TARGET(2))  dut_b (.clk(clk), .stateReset(rst), .bus(b_if));
   round_judge #(.NUM_CHOICES(5), .SCORE_W(4), .WIN_TARGET(15)) dut_c (.clk(clk), .stateReset(rst), .bus(c_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Position of the single set bit, or -1 if the vector is not one-hot.
   function automatic int ref_index(input logic [4:0] v, input int n);
      int cnt = 0;
      int pos = 0;
      for (int k = 0; k < n; k++) begin
         if (v[k]) begin
            cnt++;
            pos = k;
         end
      end
      return (cnt == 1) ? pos : -1;
   endfunction

   // 0 = draw, 1 = player 1 wins, 2 = player 2 wins.
   function automatic int ref_outcome(input int i, input int j, input int n);
      int d;
`ifdef ROUND_JUDGE_INVALID_FORFEIT_EN
      if (i < 0 && j < 0) return 0;
      if (i < 0) return 2;
      if (j < 0) return 1;
`else
      if (i < 0) i = 0;
      if (j < 0) j = 0;
`endif
      if (i == j) return 0;
      d = ((j - i) % n + n) % n;
      return (d >= 1 && d <= (n - 1) / 2) ? 1 : 2;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_if.userChoose = 1'b1;
      a_if.player1Choice = 3'b001;
      a_if.player2Choice = 3'b010;
      tick();
      tick();
      rst = 1'b0;
      a_if.userChoose = 1'b0;
      sa1 = 0; sa2 = 0; sc1 = 0; sc2 = 0;
      tests++;
      if ({a_if.scenario, a_if.resultValid, a_if.winner1, a_if.winner2, a_if.draw,
           a_if.player1, a_if.player2, a_if.gameOver, a_if.busy} !== 23'd0) begin
         fails++;
         $display("FAIL reset_a: outputs=%h expected 0", {a_if.scenario, a_if.resultValid,
                  a_if.winner1, a_if.winner2, a_if.draw, a_if.player1, a_if.player2,
                  a_if.gameOver, a_if.busy});
      end
      tests++;
      if ({b_if.busy, b_if.gameOver, c_if.busy, c_if.gameOver, c_if.scenario} !== 29'd0) begin
         fails++;
         $display("FAIL reset_bc: b busy/over=%b%b c busy/over=%b%b c scen=%h expected 0",
                  b_if.busy, b_if.gameOver, c_if.busy, c_if.gameOver, c_if.scenario);
      end
   endtask

   // One full round on instance a, holding the result for 'hold' extra cycles.
   task automatic play_a(input logic [2:0] c1, input logic [2:0] c2, input int hold);
      int i1, i2, o;
      logic [8:0] sc_exp;
      logic [3:0] fl_exp;
      logic [8:0] one9;
      bit over;
      i1 = ref_index({2'b00, c1}, 3);
      i2 = ref_index({2'b00, c2}, 3);
      o  = ref_outcome(i1, i2, 3);
      if (o == 1 && sa1 < 9) sa1++;
      if (o == 2 && sa2 < 9) sa2++;
      one9   = 9'd1;
      sc_exp = one9 << (((i1 < 0) ? 0 : i1) * 3 + ((i2 < 0) ? 0 : i2));
      fl_exp = {1'b1, (o == 1), (o == 2), (o == 0)};
      a_if.player1Choice = c1;
      a_if.player2Choice = c2;
      a_if.userChoose = 1'b1;
      tick();
      a_if.userChoose = 1'b0;
      tests++;
      if ({a_if.busy, a_if.resultValid} !== 2'b10) begin
         fails++;
         $display("FAIL judge_cycle: busy,valid=%b expected 10", {a_if.busy, a_if.resultValid});
      end
      tick();
      for (int h = 0; h <= hold; h++) begin
         tests++;
         if ({a_if.resultValid, a_if.winner1, a_if.winner2, a_if.draw} !== fl_exp) begin
            fails++;
            $display("FAIL flags p1=%b p2=%b: got %b expected %b", c1, c2,
                     {a_if.resultValid, a_if.winner1, a_if.winner2, a_if.draw}, fl_exp);
         end
         tests++;
         if (a_if.scenario !== sc_exp) begin
            fails++;
            $display("FAIL scenario p1=%b p2=%b: got %b expected %b", c1, c2, a_if.scenario, sc_exp);
         end
         tests++;
         if ({a_if.player1, a_if.player2} !== {4'(sa1), 4'(sa2)}) begin
            fails++;
            $display("FAIL scores: got %0d/%0d expected %0d/%0d", a_if.player1, a_if.player2, sa1, sa2);
         end
         if (h < hold) tick();
      end
      a_if.resultAck = 1'b1;
      tick();
      a_if.resultAck = 1'b0;
      over = (sa1 == 9) || (sa2 == 9);
      tests++;
      if ({a_if.busy, a_if.gameOver, a_if.resultValid} !== (over ? 3'b110 : 3'b000)) begin
         fails++;
         $display("FAIL after_ack: busy,over,valid=%b expected %b",
                  {a_if.busy, a_if.gameOver, a_if.resultValid}, (over ? 3'b110 : 3'b000));
      end
      if (!over) begin
         tests++;
         if (a_if.scenario !== sc_exp) begin
            fails++;
            $display("FAIL scenario_hold: got %b expected %b", a_if.scenario, sc_exp);
         end
      end else begin
         a_if.userResetGame = 1'b1;
         tick();
         a_if.userResetGame = 1'b0;
         sa1 = 0;
         sa2 = 0;
         tests++;
         if ({a_if.busy, a_if.gameOver, a_if.player1, a_if.player2} !== 10'd0) begin
            fails++;
            $display("FAIL game_reset_a: busy,over,scores=%b expected 0",
                     {a_if.busy, a_if.gameOver, a_if.player1, a_if.player2});
         end
      end
   endtask

   task automatic test_directed();
      play_a(3'b001, 3'b010, 0);   // cat vs dog
      play_a(3'b100, 3'b100, 1);   // chicken draw
      play_a(3'b010, 3'b100, 0);   // dog vs chicken
      play_a(3'b001, 3'b100, 2);   // cat vs chicken
   endtask

   task automatic test_invalid();
      play_a(3'b011, 3'b010, 0);
      play_a(3'b001, 3'b000, 0);
      play_a(3'b111, 3'b110, 0);
   endtask

   task automatic test_random();
      logic [2:0] c1, c2;
      for (int r = 0; r < 40; r++) begin
         c1 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : (3'b001 << $urandom_range(0, 2));
         c2 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : (3'b001 << $urandom_range(0, 2));
         play_a(c1, c2, int'($urandom_range(0, 2)));
      end
   endtask

   task automatic test_ack_idle();
      a_if.resultAck = 1'b1;
      tick();
      tick();
      a_if.resultAck = 1'b0;
      tests++;
      if ({a_if.busy, a_if.resultValid, a_if.player1, a_if.player2} !== {2'b00, 4'(sa1), 4'(sa2)}) begin
         fails++;
         $display("FAIL ack_in_idle: busy,valid,scores=%b expected %b",
                  {a_if.busy, a_if.resultValid, a_if.player1, a_if.player2}, {2'b00, 4'(sa1), 4'(sa2)});
      end
   endtask

   // Player 1 wins one round on instance b, acknowledged unless told otherwise.
   task automatic b_round(input bit ack);
      b_if.player1Choice = 3'b001;
      b_if.player2Choice = 3'b010;
      b_if.userChoose = 1'b1;
      tick();
      b_if.userChoose = 1'b0;
      tick();
      if (ack) begin
         b_if.resultAck = 1'b1;
         tick();
         b_if.resultAck = 1'b0;
      end
   endtask

   task automatic test_game_over();
      b_round(1'b1);
      tests++;
      if ({b_if.gameOver, b_if.busy, b_if.player1} !== {2'b00, 4'd1}) begin
         fails++;
         $display("FAIL over_first_win: over,busy,p1=%b expected 000001", {b_if.gameOver, b_if.busy, b_if.player1});
      end
      b_round(1'b1);
      tests++;
      if ({b_if.gameOver, b_if.busy, b_if.player1, b_if.player2} !== {2'b11, 4'd2, 4'd0}) begin
         fails++;
         $display("FAIL over_reached: over,busy,p1,p2=%b expected 11_0010_0000",
                  {b_if.gameOver, b_if.busy, b_if.player1, b_if.player2});
      end
      b_round(1'b1);   // should be ignored in OVER
      tick();
      tests++;
      if ({b_if.gameOver, b_if.resultValid, b_if.player1, b_if.player2} !== {2'b10, 4'd2, 4'd0}) begin
         fails++;
         $display("FAIL over_ignores_choose: over,valid,p1,p2=%b expected 10_0010_0000",
                  {b_if.gameOver, b_if.resultValid, b_if.player1, b_if.player2});
      end
      b_if.userResetGame = 1'b1;
      tick();
      b_if.userResetGame = 1'b0;
      tests++;
      if ({b_if.gameOver, b_if.busy, b_if.player1, b_if.player2} !== 10'd0) begin
         fails++;
         $display("FAIL over_reset: over,busy,p1,p2=%b expected 0", {b_if.gameOver, b_if.busy, b_if.player1, b_if.player2});
      end
   endtask

   task automatic test_reset_with_ack();
      b_round(1'b1);
      b_round(1'b0);   // now in SHOW with player1 at target
      tests++;
      if ({b_if.resultValid, b_if.player1} !== {1'b1, 4'd2}) begin
         fails++;
         $display("FAIL rst_ack_setup: valid,p1=%b expected 10010", {b_if.resultValid, b_if.player1});
      end
      b_if.userResetGame = 1'b1;
      b_if.resultAck = 1'b1;
      tick();
      b_if.userResetGame = 1'b0;
      b_if.resultAck = 1'b0;
      tick();
      tests++;
      if ({b_if.gameOver, b_if.busy, b_if.resultValid, b_if.scenario, b_if.player1, b_if.player2} !== 20'd0) begin
         fails++;
         $display("FAIL rst_ack_together: over,busy,valid,scen,p1,p2=%b expected 0",
                  {b_if.gameOver, b_if.busy, b_if.resultValid, b_if.scenario, b_if.player1, b_if.player2});
      end
   endtask

   task automatic test_sweep5();
      logic [24:0] one25;
      logic [24:0] sc_exp;
      int o;
      one25 = 25'd1;
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 5; j++) begin
            o = ref_outcome(i, j, 5);
            if (o == 1) sc1++;
            if (o == 2) sc2++;
            sc_exp = one25 << (i * 5 + j);
            c_if.player1Choice = 5'b00001 << i;
            c_if.player2Choice = 5'b00001 << j;
            c_if.userChoose = 1'b1;
            tick();
            c_if.userChoose = 1'b0;
            tick();
            tests++;
            if ({c_if.resultValid, c_if.winner1, c_if.winner2, c_if.draw, c_if.scenario} !==
                {1'b1, (o == 1), (o == 2), (o == 0), sc_exp}) begin
               fails++;
               $display("FAIL sweep5 i=%0d j=%0d: valid,w1,w2,draw=%b scen=%h expected outcome %0d scen=%h",
                        i, j, {c_if.resultValid, c_if.winner1, c_if.winner2, c_if.draw}, c_if.scenario, o, sc_exp);
            end
            c_if.resultAck = 1'b1;
            tick();
            c_if.resultAck = 1'b0;
         end
      end
      tests++;
      if ({c_if.player1, c_if.player2, c_if.busy, c_if.gameOver} !== {4'(sc1), 4'(sc2), 2'b00}) begin
         fails++;
         $display("FAIL sweep5_scores: p1=%0d p2=%0d busy=%b over=%b expected %0d/%0d idle",
                  c_if.player1, c_if.player2, c_if.busy, c_if.gameOver, sc1, sc2);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      a_if.userChoose = 1'b0; a_if.userResetGame = 1'b0; a_if.resultAck = 1'b0;
      a_if.player1Choice = 3'b000; a_if.player2Choice = 3'b000;
      b_if.userChoose = 1'b0; b_if.userResetGame = 1'b0; b_if.resultAck = 1'b0;
      b_if.player1Choice = 3'b000; b_if.player2Choice = 3'b000;
      c_if.userChoose = 1'b0; c_if.userResetGame = 1'b0; c_if.resultAck = 1'b0;
      c_if.player1Choice = 5'b00000; c_if.player2Choice = 5'b00000;
      test_reset();
      test_directed();
      test_invalid();
      test_ack_idle();
      test_random();
      test_game_over();
      test_reset_with_ack();
      test_sweep5();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
